// File: rtl/rc4_chk_pkg.sv
// Shared state encoding and character constants for the RC4 plaintext checker.
package rc4_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } chk_state_t;

    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_LO_A  = 8'h61;
    localparam logic [7:0] CHR_LO_Z  = 8'h7A;
    localparam logic [7:0] CHR_UP_A  = 8'h41;
    localparam logic [7:0] CHR_UP_Z  = 8'h5A;

endpackage

// File: rtl/rc4_char_class.sv
// Combinational plaintext character classifier: lowercase a-z and space are valid.
// RC4_CHK_UPPER_EN additionally accepts uppercase A-Z.
module rc4_char_class
    import rc4_chk_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              valid
);

    logic is_space;
    logic is_lower;
    logic is_upper;

    // Full-width unsigned compares, so anything at or above 0x80 falls out.
    assign is_space = (data == DATA_W'(CHR_SPACE));
    assign is_lower = (data >= DATA_W'(CHR_LO_A)) && (data <= DATA_W'(CHR_LO_Z));

`ifdef RC4_CHK_UPPER_EN
    assign is_upper = (data >= DATA_W'(CHR_UP_A)) && (data <= DATA_W'(CHR_UP_Z));
`else
    assign is_upper = 1'b0;
`endif

    assign valid = is_space || is_lower || is_upper;

endmodule

// File: rtl/rc4_msg_checker.sv
// Walks the decrypted-message RAM and aborts on the first byte outside the plaintext set.
// Build option: RC4_CHK_UPPER_EN widens the accepted set to include uppercase.
module rc4_msg_checker
    import rc4_chk_pkg::*;
#(
    parameter int MSG_LEN    = 32,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] q_d,
    output logic [ADDR_W-1:0] address_d,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] error_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);
    localparam int                WAIT_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    chk_state_t        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d_n;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] error_addr_q, error_addr_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic              byte_valid;

    rc4_char_class #(.DATA_W(DATA_W)) u_class (
        .data  (q_d),
        .valid (byte_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            address_q    <= '0;
            error_q      <= 1'b0;
            error_addr_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d_n;
            error_q      <= error_d;
            error_addr_q <= error_addr_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        address_d_n  = address_q;
        error_d      = error_q;
        error_addr_d = error_addr_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                address_d_n = '0;
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wait_cnt_d = '0;
                state_d    = (RD_LATENCY > 0) ? ST_WAIT : ST_CHECK;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'(WAIT_LAST)) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_CHECK: begin
                if (!byte_valid) begin
                    error_d      = 1'b1;
                    error_addr_d = address_q;
                    state_d      = ST_DONE;
                end else if (address_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    address_d_n = address_q + ADDR_W'(1);
                    state_d     = ST_FETCH;
                end
            end
            ST_DONE: begin
                // Result holds until the controller drops start.
                if (!start) begin
                    state_d      = ST_IDLE;
                    address_d_n  = '0;
                    error_d      = 1'b0;
                    error_addr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign address_d  = address_q;
    assign finished   = (state_q == ST_DONE);
    assign error      = error_q;
    assign error_addr = error_addr_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_rc4_msg_checker.sv
// Directed bench: 32-byte/latency-1 checker plus a 16-byte/latency-0 instance.
module tb_rc4_msg_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: MSG_LEN=32, ADDR_W=5, RD_LATENCY=1
    logic       rst1, start1;
    logic [7:0] q1;
    logic [4:0] addr1, eaddr1;
    logic       fin1, err1, busy1;
    logic [7:0] mem1 [32];

    // Instance 2: MSG_LEN=16, ADDR_W=4, RD_LATENCY=0
    logic       rst2, start2;
    logic [7:0] q2;
    logic [3:0] addr2, eaddr2;
    logic       fin2, err2, busy2;
    logic [7:0] mem2 [16];

    int n_checks = 0;
    int n_fail   = 0;

    rc4_msg_checker #(.MSG_LEN(32), .ADDR_W(5), .DATA_W(8), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(rst1), .start(start1), .q_d(q1), .address_d(addr1),
        .finished(fin1), .error(err1), .error_addr(eaddr1), .busy(busy1)
    );

    rc4_msg_checker #(.MSG_LEN(16), .ADDR_W(4), .DATA_W(8), .RD_LATENCY(0)) dut16 (
        .clk(clk), .reset(rst2), .start(start2), .q_d(q2), .address_d(addr2),
        .finished(fin2), .error(err2), .error_addr(eaddr2), .busy(busy2)
    );

    // One-cycle registered RAM read and a combinational one.
    always @(posedge clk) q1 <= mem1[addr1];
    assign q2 = mem2[addr2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_hello();
        string s;
        s = "hello world";
        for (int i = 0; i < 32; i++) begin
            if (i < s.len()) mem1[i] = s[i];
            else             mem1[i] = 8'h61 + 8'(i % 26);
        end
    endtask

    task automatic go_idle1();
        start1 = 1'b0;
        tick();
        tick();
    endtask

    // Raises start and counts edges until finished; cyc = limit+1 on timeout.
    task automatic run1(input int limit, output int cyc, output int max_a, output bit seq_ok);
        int prev;
        cyc = 0; max_a = 0; seq_ok = 1'b1; prev = 0;
        start1 = 1'b1;
        while (cyc <= limit) begin
            tick();
            cyc++;
            if (int'(addr1) != prev && int'(addr1) != prev + 1) seq_ok = 1'b0;
            prev = int'(addr1);
            if (int'(addr1) > max_a) max_a = int'(addr1);
            if (fin1) break;
        end
    endtask

    task automatic run2(input int limit, output int cyc);
        cyc = 0;
        start2 = 1'b1;
        while (cyc <= limit) begin
            tick();
            cyc++;
            if (fin2) break;
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        tick(); tick();
        rst1 = 1'b0; rst2 = 1'b0;
        n_checks++;
        if ({fin1, err1, busy1, addr1, eaddr1} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_state: got fin=%b err=%b busy=%b addr=%0d eaddr=%0d, want all 0",
                     fin1, err1, busy1, addr1, eaddr1);
        end
    endtask

    task automatic test_valid_msg();
        int cyc, max_a; bit seq_ok;
        fill_hello();
        run1(200, cyc, max_a, seq_ok);
        n_checks++;
        if (cyc !== 97) begin
            n_fail++; $display("FAIL valid_latency: got %0d cycles, want 97", cyc);
        end
        n_checks++;
        if (err1 !== 1'b0) begin
            n_fail++; $display("FAIL valid_error: got %b, want 0", err1);
        end
        n_checks++;
        if (!seq_ok || max_a !== 31) begin
            n_fail++; $display("FAIL valid_sweep: in_order=%b max=%0d, want 1 / 31", seq_ok, max_a);
        end
        go_idle1();
    endtask

    task automatic test_invalid_byte();
        int cyc, max_a; bit seq_ok;
        fill_hello();
        mem1[5] = 8'h21;
        run1(200, cyc, max_a, seq_ok);
        n_checks++;
        if (cyc !== 19 || err1 !== 1'b1 || eaddr1 !== 5'd5) begin
            n_fail++;
            $display("FAIL bang_byte: got cyc=%0d err=%b eaddr=%0d, want 19/1/5", cyc, err1, eaddr1);
        end
        n_checks++;
        if (max_a > 5) begin
            n_fail++; $display("FAIL bang_addr_bound: got max addr %0d, want <= 5", max_a);
        end
        go_idle1();
    endtask

    task automatic test_upper();
        int cyc, max_a; bit seq_ok;
        fill_hello();
        mem1[0] = 8'h41;
        run1(200, cyc, max_a, seq_ok);
        n_checks++;
`ifdef RC4_CHK_UPPER_EN
        if (cyc !== 97 || err1 !== 1'b0) begin
            n_fail++; $display("FAIL upper_a: got cyc=%0d err=%b, want 97/0", cyc, err1);
        end
`else
        if (cyc !== 4 || err1 !== 1'b1 || eaddr1 !== 5'd0) begin
            n_fail++;
            $display("FAIL upper_a: got cyc=%0d err=%b eaddr=%0d, want 4/1/0", cyc, err1, eaddr1);
        end
`endif
        go_idle1();
        // 0x80 sits above the allowed range on an unsigned compare
        fill_hello();
        mem1[2] = 8'h80;
        run1(200, cyc, max_a, seq_ok);
        n_checks++;
        if (cyc !== 10 || err1 !== 1'b1 || eaddr1 !== 5'd2) begin
            n_fail++;
            $display("FAIL high_byte: got cyc=%0d err=%b eaddr=%0d, want 10/1/2", cyc, err1, eaddr1);
        end
        go_idle1();
    endtask

    task automatic test_reset_mid_scan();
        int cyc, max_a, guard; bit seq_ok;
        fill_hello();
        start1 = 1'b1;
        guard = 0;
        while (addr1 !== 5'd10 && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++; $display("FAIL midscan_reach: addr stuck at %0d, want 10", addr1);
        end
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        n_checks++;
        if (fin1 !== 1'b0 || busy1 !== 1'b0 || addr1 !== 5'd0) begin
            n_fail++;
            $display("FAIL midscan_reset: got fin=%b busy=%b addr=%0d, want 0/0/0", fin1, busy1, addr1);
        end
        run1(200, cyc, max_a, seq_ok);
        n_checks++;
        if (cyc !== 97 || err1 !== 1'b0 || max_a !== 31) begin
            n_fail++;
            $display("FAIL midscan_rescan: got cyc=%0d err=%b max=%0d, want 97/0/31", cyc, err1, max_a);
        end
        go_idle1();
    endtask

    task automatic test_start_held();
        int cyc, max_a; bit seq_ok, held_ok;
        fill_hello();
        mem1[7] = 8'h7B;
        run1(200, cyc, max_a, seq_ok);
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fin1 !== 1'b1 || busy1 !== 1'b0 || err1 !== 1'b1 || eaddr1 !== 5'd7) held_ok = 1'b0;
        end
        n_checks++;
        if (!held_ok || cyc !== 25) begin
            n_fail++;
            $display("FAIL start_held: got cyc=%0d held_ok=%b fin=%b err=%b, want 25/1/1/1", cyc, held_ok, fin1, err1);
        end
        start1 = 1'b0;
        tick();
        n_checks++;
        if (fin1 !== 1'b0 || err1 !== 1'b0 || eaddr1 !== 5'd0) begin
            n_fail++;
            $display("FAIL start_drop: got fin=%b err=%b eaddr=%0d, want 0/0/0", fin1, err1, eaddr1);
        end
        fill_hello();
        run1(200, cyc, max_a, seq_ok);
        n_checks++;
        if (cyc !== 97 || err1 !== 1'b0) begin
            n_fail++; $display("FAIL fresh_scan: got cyc=%0d err=%b, want 97/0", cyc, err1);
        end
        go_idle1();
    endtask

    task automatic test_len16();
        int cyc;
        for (int i = 0; i < 16; i++) mem2[i] = 8'h20;
        run2(100, cyc);
        n_checks++;
        if (cyc !== 33 || err2 !== 1'b0 || addr2 !== 4'd15) begin
            n_fail++;
            $display("FAIL len16_spaces: got cyc=%0d err=%b addr=%0d, want 33/0/15", cyc, err2, addr2);
        end
        start2 = 1'b0; tick(); tick();
        mem2[15] = 8'hFF;
        run2(100, cyc);
        n_checks++;
        if (cyc !== 33 || err2 !== 1'b1 || eaddr2 !== 4'd15) begin
            n_fail++;
            $display("FAIL len16_last_bad: got cyc=%0d err=%b eaddr=%0d, want 33/1/15", cyc, err2, eaddr2);
        end
        start2 = 1'b0; tick(); tick();
        mem2[15] = 8'h7A;
        mem2[3]  = 8'h60;
        run2(100, cyc);
        n_checks++;
        if (cyc !== 9 || err2 !== 1'b1 || eaddr2 !== 4'd3) begin
            n_fail++;
            $display("FAIL len16_below_a: got cyc=%0d err=%b eaddr=%0d, want 9/1/3", cyc, err2, eaddr2);
        end
        start2 = 1'b0; tick(); tick();
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 32; i++) mem1[i] = 8'h20;
        for (int i = 0; i < 16; i++) mem2[i] = 8'h20;
        test_reset();
        test_valid_msg();
        test_invalid_byte();
        test_upper();
        test_reset_mid_scan();
        test_start_held();
        test_len16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
